// File: rtl/slice_log_pkg.sv
// Shared widths and entry field layout for the slice log capture path.
// Entry layout, MSB first: {ovf1, ovf2, tag, value}.
package slice_log_pkg;

  localparam int DATA_W_DEF  = 24;
  localparam int TAG_W_DEF   = 4;
  localparam int DEPTH_DEF   = 16;
  localparam int ENTRY_W_DEF = DATA_W_DEF + TAG_W_DEF + 2;

  function automatic int entry_w(input int data_w, input int tag_w);
    return data_w + tag_w + 2;
  endfunction

  function automatic int value_lsb();
    return 0;
  endfunction

  function automatic int tag_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int ovf2_bit(input int data_w, input int tag_w);
    return data_w + tag_w;
  endfunction

  function automatic int ovf1_bit(input int data_w, input int tag_w);
    return data_w + tag_w + 1;
  endfunction

endpackage

// File: rtl/slice_log_fifo.sv
// Single-clock FIFO with registered level/full/empty; storage has no reset
// and an asynchronous head read so it maps onto distributed RAM.
module slice_log_fifo #(
  parameter int WIDTH = slice_log_pkg::ENTRY_W_DEF,
  parameter int DEPTH = slice_log_pkg::DEPTH_DEF
) (
  input  logic                       clock_200,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             full_reg, empty_reg;
  logic             push, pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop  = rd_en & ~empty_reg & ~flush;
  assign push = wr_en & ~flush & (~full_reg | pop);

  always_comb begin
    level_next = level_reg;
    if (flush) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level_reg + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = level_reg - LVL_W'(1);
    end
  end

  always_ff @(posedge clock_200 or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      level_reg <= level_next;
      full_reg  <= (level_next == LVL_W'(DEPTH));
      empty_reg <= (level_next == '0);
    end
  end

  always_ff @(posedge clock_200) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign level     = level_reg;
  assign full      = full_reg;
  assign empty     = empty_reg;

endmodule

// File: rtl/slice_log_capture.sv
// Captures slice log strobes into a FIFO for host readout, counting strobes
// lost to a full FIFO. DEPTH must be a power of two so pointers wrap cleanly.
module slice_log_capture
  import slice_log_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                         clock_200,
  input  logic                         reset,
  input  logic                         capture_enable,
  input  logic                         log_trigger,
  input  logic [DATA_W-1:0]            log_value_in,
  input  logic [TAG_W-1:0]             log_tag,
  input  logic                         overflow_stage_1,
  input  logic                         overflow_stage_2,
  input  logic                         rd_en,
  input  logic                         flush,
  output logic [DATA_W+TAG_W+1:0]      rd_data,
  output logic                         rd_valid,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       level,
  output logic [7:0]                   drop_count
);

  localparam int ENTRY_W = entry_w(DATA_W, TAG_W);
  localparam int TAG_LSB = tag_lsb(DATA_W);
  localparam int OVF1    = ovf1_bit(DATA_W, TAG_W);
  localparam int OVF2    = ovf2_bit(DATA_W, TAG_W);

  logic [ENTRY_W-1:0] wr_entry, head_entry;
  logic [ENTRY_W-1:0] rd_data_reg;
  logic               rd_valid_reg;
  logic [7:0]         drop_count_reg;
  logic               push_req, pop_accept, drop;
  logic               fifo_full, fifo_empty;

  always_comb begin
    wr_entry = '0;
    wr_entry[value_lsb() +: DATA_W] = log_value_in;
    wr_entry[TAG_LSB +: TAG_W]      = log_tag;
    wr_entry[OVF2]                  = overflow_stage_2;
    wr_entry[OVF1]                  = overflow_stage_1;
  end

  assign push_req   = log_trigger & capture_enable & ~flush;
  assign pop_accept = rd_en & ~flush & ~fifo_empty;
  // Full implies non-empty, so a same-cycle rd_en always makes room.
  assign drop       = push_req & fifo_full & ~rd_en;

  slice_log_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_200 (clock_200),
    .reset     (reset),
    .flush     (flush),
    .wr_en     (push_req),
    .wr_data   (wr_entry),
    .rd_en     (rd_en),
    .head_data (head_entry),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock_200 or posedge reset) begin
    if (reset) begin
      rd_data_reg    <= '0;
      rd_valid_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      rd_valid_reg <= pop_accept;
      if (pop_accept) rd_data_reg <= head_entry;
      if (flush) begin
        drop_count_reg <= '0;
      end else if (drop && drop_count_reg != 8'hFF) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  assign rd_data    = rd_data_reg;
  assign rd_valid   = rd_valid_reg;
  assign drop_count = drop_count_reg;
  assign full       = fifo_full;
  assign empty      = fifo_empty;

endmodule

// File: tb/tb_slice_log_capture.sv
// Directed and random checks of slice_log_capture against a queue-based model.
module tb_slice_log_capture;

  localparam int DW    = 24;
  localparam int TW    = 4;
  localparam int DEPTH = 16;
  localparam int EW    = DW + TW + 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock_200 = 1'b0;
  logic          reset = 1'b1;
  logic          capture_enable = 1'b0;
  logic          log_trigger = 1'b0;
  logic [DW-1:0] log_value_in = '0;
  logic [TW-1:0] log_tag = '0;
  logic          overflow_stage_1 = 1'b0;
  logic          overflow_stage_2 = 1'b0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic [EW-1:0] rd_data;
  logic          rd_valid, empty, full;
  logic [LW-1:0] level;
  logic [7:0]    drop_count;

  slice_log_capture #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEPTH)) dut (
    .clock_200        (clock_200),
    .reset            (reset),
    .capture_enable   (capture_enable),
    .log_trigger      (log_trigger),
    .log_value_in     (log_value_in),
    .log_tag          (log_tag),
    .overflow_stage_1 (overflow_stage_1),
    .overflow_stage_2 (overflow_stage_2),
    .rd_en            (rd_en),
    .flush            (flush),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .empty            (empty),
    .full             (full),
    .level            (level),
    .drop_count       (drop_count)
  );

  always #5 clock_200 = ~clock_200;

  int            vectors = 0;
  int            miscompares = 0;
  logic [EW-1:0] model_q[$];
  int            model_drops = 0;
  logic          model_valid = 1'b0;
  logic [EW-1:0] model_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(model_q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
    chk({tag, ".drop"}, 32'(drop_count), 32'(model_drops));
    chk({tag, ".valid"}, 32'(rd_valid), 32'(model_valid));
    chk({tag, ".data"}, 32'(rd_data), 32'(model_data));
  endtask

  // One clock of stimulus; the model applies the behavioural rules directly.
  task automatic cycle(input string tag, input logic trg, input logic en, input logic rde,
                       input logic fl, input logic [DW-1:0] v, input logic [TW-1:0] t,
                       input logic o1, input logic o2);
    bit pop_ok;
    log_trigger = trg; capture_enable = en; rd_en = rde; flush = fl;
    log_value_in = v; log_tag = t; overflow_stage_1 = o1; overflow_stage_2 = o2;
    pop_ok = rde && !fl && model_q.size() > 0;
    if (fl) begin
      model_q.delete();
      model_drops = 0;
      model_valid = 1'b0;
    end else begin
      model_valid = pop_ok;
      if (pop_ok) model_data = model_q.pop_front();
      if (trg && en) begin
        if (model_q.size() < DEPTH) model_q.push_back({o1, o2, t, v});
        else if (model_drops < 255) model_drops++;
      end
    end
    @(posedge clock_200);
    #1;
    check_all(tag);
  endtask

  task automatic push(input string tag, input logic [DW-1:0] v, input logic [TW-1:0] t);
    cycle(tag, 1'b1, 1'b1, 1'b0, 1'b0, v, t, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    cycle(tag, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] vals [4];
    logic [TW-1:0] tags [4];
    vals[0] = 24'd100; vals[1] = -24'sd200; vals[2] = 24'h7FFFFF; vals[3] = 24'h800000;
    tags[0] = 4'd0; tags[1] = 4'd4; tags[2] = 4'd6; tags[3] = 4'd9;

    repeat (3) @(posedge clock_200);
    #2 reset = 1'b0;
    #1 check_all("reset");

    // Ordered capture of sign-extreme values
    for (int i = 0; i < 4; i++) push("ord_push", vals[i], tags[i]);
    chk("ord_level4", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      pop("ord_pop");
      chk("ord_value", 32'(rd_data[DW-1:0]), 32'(vals[i]));
      chk("ord_tag", 32'(rd_data[DW +: TW]), 32'(tags[i]));
    end
    idle("ord_idle");

    // Fill, overflow drops, then push+pop while full
    for (int i = 0; i < DEPTH + 3; i++) push("fill", DW'($urandom), TW'($urandom));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_drop3", 32'(drop_count), 32'd3);
    cycle("full_pushpop", 1'b1, 1'b1, 1'b1, 1'b0, 24'h123456, 4'd3, 1'b0, 1'b0);
    chk("full_level16", 32'(level), 32'd16);
    chk("full_drop3", 32'(drop_count), 32'd3);

    // Push and pop on an empty FIFO
    cycle("flush_a", 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    cycle("empty_pushpop", 1'b1, 1'b1, 1'b1, 1'b0, 24'd500, 4'd1, 1'b0, 1'b0);
    chk("empty_novalid", 32'(rd_valid), 32'd0);
    chk("empty_level1", 32'(level), 32'd1);
    pop("empty_pop500");
    chk("pop500", 32'(rd_data[DW-1:0]), 32'd500);

    // Capture disabled
    for (int i = 0; i < 10; i++)
      cycle("disabled", 1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom), TW'($urandom), 1'b0, 1'b0);
    chk("dis_level0", 32'(level), 32'd0);

    // Flush beats same-cycle push and pop
    for (int i = 0; i < 5; i++) push("load5", DW'($urandom), TW'($urandom));
    cycle("flush_all", 1'b1, 1'b1, 1'b1, 1'b1, 24'd7, 4'd7, 1'b0, 1'b0);
    chk("flush_level0", 32'(level), 32'd0);
    chk("flush_novalid", 32'(rd_valid), 32'd0);

    // Asynchronous reset mid-fill with drops and a stale rd_data pending
    for (int i = 0; i < DEPTH + 2; i++) push("prefill", DW'($urandom), TW'($urandom));
    pop("prefill_pop");
    cycle("midfill", 1'b1, 1'b1, 1'b0, 1'b0, 24'd9, 4'd2, 1'b0, 1'b0);
    log_trigger = 1'b0; rd_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_level", 32'(level), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_full", 32'(full), 32'd0);
    chk("async_drop", 32'(drop_count), 32'd0);
    chk("async_valid", 32'(rd_valid), 32'd0);
    chk("async_data", 32'(rd_data), 32'd0);
    model_q.delete(); model_drops = 0; model_valid = 1'b0; model_data = '0;
    @(posedge clock_200);
    #3 reset = 1'b0;
    idle("post_reset");

    // Overflow flag placement
    cycle("ovf_push", 1'b1, 1'b1, 1'b0, 1'b0, 24'hABCDE, 4'd5, 1'b1, 1'b0);
    pop("ovf_pop");
    chk("ovf_top6", 32'(rd_data[EW-1 -: 6]), 32'b100101);

    // Random traffic, first biased toward filling, then toward draining
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(99) < 60),
            ($urandom_range(99) < 85),
            ($urandom_range(99) < ((i < 200) ? 25 : 65)),
            ($urandom_range(99) < 2),
            DW'($urandom), TW'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slice_log_capture.md
SLICE_LOG_CAPTURE -- requirements
Module: slice_log_capture

Interface
REQ-001 Parameter DATA_W, default 24, width of the signed slice log value.
REQ-002 Parameter TAG_W, default 4, width of the state-address tag.
REQ-003 Parameter DEPTH, default 16, FIFO entries; power of two only.
REQ-004 clock_200  in  1  the only clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 capture_enable  in  1  when low, log_trigger is ignored and nothing is counted.
REQ-007 log_trigger  in  1  one-cycle strobe from the slice; its value and tag are valid in the same cycle.
REQ-008 log_value_in  in  DATA_W  signed slice log value.
REQ-009 log_tag  in  TAG_W  state write address of the logged value.
REQ-010 overflow_stage_1, overflow_stage_2  in  1 each  slice overflow flags, sampled with the trigger.
REQ-011 rd_en  in  1  host pop request.
REQ-012 flush  in  1  synchronous FIFO clear.
REQ-013 rd_data  out  DATA_W+TAG_W+2  entry {ovf1, ovf2, tag, value}, MSB first.
REQ-014 rd_valid  out  1  one-cycle strobe; rd_data is valid while it is high.
REQ-015 empty, full  out  1 each  FIFO status.
REQ-016 level  out  log2(DEPTH)+1  current occupancy.
REQ-017 drop_count  out  8  count of triggers lost to a full FIFO.

Function
REQ-018 Push: log_trigger & capture_enable & ~flush writes {overflow_stage_1, overflow_stage_2, log_tag, log_value_in} from that same cycle.
REQ-019 Pop: rd_en & ~empty & ~flush pops the head entry; rd_data and rd_valid are registered and appear exactly 1 cycle after the accepted rd_en.
REQ-020 rd_en while empty is ignored: no rd_valid, rd_data holds its last value, no error.
REQ-021 Push while full with no pop in the same cycle: entry discarded, drop_count += 1, saturating at 255.
REQ-022 Push and pop in the same cycle while full: both occur, level unchanged, no drop.
REQ-023 Push and pop in the same cycle while empty: push occurs, pop is ignored, level becomes 1.
REQ-024 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; full = (level == DEPTH), empty = (level == 0).
REQ-025 flush sets both pointers and level to 0, clears drop_count and deasserts rd_valid next cycle; it beats a same-cycle push or pop.
REQ-026 Status outputs (empty, full, level, drop_count) are registered and reflect all updates one cycle after the causing edge.
REQ-027 Entries leave the FIFO in strict arrival order; no value arithmetic is applied (value passes bit-exact, sign preserved).

Reset
REQ-028 On reset assertion, asynchronously: pointers = 0, level = 0, empty = 1, full = 0, drop_count = 0, rd_valid = 0, rd_data = 0.
REQ-029 A trigger or rd_en coincident with reset deassertion is ignored; operation starts on the next edge.
REQ-030 Reset mid-stream discards all stored entries; no partial pop result is emitted.

Structure
REQ-031 Shared package slice_log_pkg holds DATA_W/TAG_W defaults, entry width, and the bit offsets of the entry fields.
REQ-032 Storage is one sub-module, slice_log_fifo: synchronous single-clock FIFO with level, full and empty, inferable as distributed RAM.
REQ-033 The top level adds only capture gating, the drop counter, entry packing, and the output register.

Verification
REQ-034 Enable on; pulse log_trigger for tags 0, 4, 6, 9 with values 100, -200, 0x7FFFFF, 0x800000 -> level = 4; four pops return those entries in order, each 1 cycle after its rd_en.
REQ-035 Fill 16 entries, send 3 more triggers -> full = 1, drop_count = 3; then trigger with rd_en in the same cycle -> level stays 16, drop_count stays 3.
REQ-036 Empty FIFO; rd_en and trigger (value 500) in the same cycle -> no rd_valid, level = 1; next pop returns 500.
REQ-037 capture_enable = 0 with 10 triggers -> level = 0, drop_count = 0.
REQ-038 Load 5 entries; assert flush together with a trigger and rd_en -> level = 0, no rd_valid; then assert reset mid-fill -> all outputs at REQ-028 values immediately, without waiting for a clock edge.
REQ-039 Overflow flags: trigger with ovf1 = 1, ovf2 = 0, tag 5 -> rd_data top bits read 1, 0, 0101.
